// File: rtl/stage_sequencer_if.sv
// Control/status bundle between the core's stage controller and the stage sequencer.
// The master drives the control requests and the slave (the sequencer) drives status.
interface stage_sequencer_if #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned PC_WIDTH   = 8,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  start;
  logic                  stall;
  logic                  halt;
  logic                  redirect;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic [PC_WIDTH-1:0]   pc;
  logic [NUM_STAGES-1:0] stage_valid;
  logic                  fetch_en;
  logic                  retire;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  instr_count;

  modport master (
    output start, stall, halt, redirect, redirect_pc,
    input  pc, stage_valid, fetch_en, retire, busy, instr_count
  );

  modport slave (
    input  start, stall, halt, redirect, redirect_pc,
    output pc, stage_valid, fetch_en, retire, busy, instr_count
  );
endinterface

// File: rtl/stage_sequencer.sv
// Stage-token sequencer and PC generator for the MIPS core stage enables.
// Multicycle mode circulates one token; pipelined mode issues one instruction per cycle.
module stage_sequencer #(
  parameter int unsigned NUM_STAGES     = 5,
  parameter int unsigned PC_WIDTH       = 8,
  parameter int unsigned PC_STEP        = 1,
  parameter int unsigned PIPELINED      = 0,
  parameter int unsigned REDIRECT_STAGE = 2,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  stage_sequencer_if.slave  seq_if
);

  localparam int unsigned LAST = NUM_STAGES - 1;
  // Stages below REDIRECT_STAGE hold younger instructions that a redirect squashes.
  localparam logic [NUM_STAGES-1:0] KEEP_MASK = {NUM_STAGES{1'b1}} << REDIRECT_STAGE;

  if (NUM_STAGES < 2) begin : g_bad_stages
    $error("stage_sequencer: NUM_STAGES must be at least 2");
  end
  if ((REDIRECT_STAGE < 1) || (REDIRECT_STAGE > NUM_STAGES - 1)) begin : g_bad_redirect
    $error("stage_sequencer: REDIRECT_STAGE out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [NUM_STAGES-1:0] sv_q, sv_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic                  issue;

  assign pc_inc = pc_q + PC_WIDTH'(PC_STEP);
  assign issue  = (state_q == S_RUN) & ~seq_if.halt & ~seq_if.redirect;

  // Next-state logic; a stalled cycle leaves every register untouched.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sv_d    = sv_q;
    cnt_d   = cnt_q;
    if (!seq_if.stall) begin
      if (sv_q[LAST]) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
      unique case (state_q)
        S_IDLE: begin
          if (seq_if.start) begin
            state_d = S_RUN;
            sv_d    = NUM_STAGES'(1);
          end
        end
        S_RUN, S_DRAIN: begin
          if (PIPELINED != 0) begin
            sv_d = {sv_q[NUM_STAGES-2:0], issue};
            if (seq_if.redirect) begin
              sv_d = sv_d & KEEP_MASK;
              pc_d = seq_if.redirect_pc;
            end else if (sv_q[0]) begin
              pc_d = pc_inc;
            end
            if ((state_q == S_RUN) && seq_if.halt) begin
              state_d = S_DRAIN;
            end else if ((state_q == S_DRAIN) && (sv_d == '0)) begin
              state_d = S_IDLE;
            end
          end else begin
            // Token wraps to stage 0 on the retire edge unless draining.
            if (sv_q[LAST]) begin
              pc_d = seq_if.redirect ? seq_if.redirect_pc : pc_inc;
              if (state_q == S_DRAIN) begin
                sv_d    = '0;
                state_d = S_IDLE;
              end else begin
                sv_d = NUM_STAGES'(1);
              end
            end else begin
              sv_d = sv_q << 1;
            end
            if ((state_q == S_RUN) && seq_if.halt) begin
              state_d = S_DRAIN;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          sv_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      sv_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sv_q    <= sv_d;
      cnt_q   <= cnt_d;
    end
  end

  assign seq_if.pc          = pc_q;
  assign seq_if.stage_valid = sv_q;
  assign seq_if.fetch_en    = sv_q[0] & ~seq_if.stall;
  assign seq_if.retire      = sv_q[LAST] & ~seq_if.stall;
  assign seq_if.busy        = (state_q != S_IDLE);
  assign seq_if.instr_count = cnt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: a multicycle and a pipelined instance run side by side
// against an instruction-list reference model, with a queue-based scoreboard.
module tb_stage_sequencer;

  localparam int N    = 5;
  localparam int R    = 2;
  localparam int PCW0 = 4;
  localparam int PCW1 = 8;
  localparam int CW0  = 16;
  localparam int CW1  = 6;

  typedef struct packed {
    logic [7:0]   pc;
    logic [N-1:0] sv;
    logic         fe;
    logic         rt;
    logic         busy;
    logic [15:0]  cnt;
  } obs_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic       in_start [2];
  logic       in_stall [2];
  logic       in_halt  [2];
  logic       in_redir [2];
  logic [7:0] in_rpc   [2];

  stage_sequencer_if #(.NUM_STAGES(N), .PC_WIDTH(PCW0), .CNT_WIDTH(CW0)) mc_if ();
  stage_sequencer_if #(.NUM_STAGES(N), .PC_WIDTH(PCW1), .CNT_WIDTH(CW1)) pl_if ();

  assign mc_if.start       = in_start[0];
  assign mc_if.stall       = in_stall[0];
  assign mc_if.halt        = in_halt[0];
  assign mc_if.redirect    = in_redir[0];
  assign mc_if.redirect_pc = in_rpc[0][PCW0-1:0];
  assign pl_if.start       = in_start[1];
  assign pl_if.stall       = in_stall[1];
  assign pl_if.halt        = in_halt[1];
  assign pl_if.redirect    = in_redir[1];
  assign pl_if.redirect_pc = in_rpc[1];

  stage_sequencer #(.NUM_STAGES(N), .PC_WIDTH(PCW0), .PC_STEP(1), .PIPELINED(0),
                    .REDIRECT_STAGE(R), .CNT_WIDTH(CW0))
    u_mc (.clock(clock), .reset_n(reset_n), .seq_if(mc_if.slave));

  stage_sequencer #(.NUM_STAGES(N), .PC_WIDTH(PCW1), .PC_STEP(1), .PIPELINED(1),
                    .REDIRECT_STAGE(R), .CNT_WIDTH(CW1))
    u_pl (.clock(clock), .reset_n(reset_n), .seq_if(pl_if.slave));

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  obs_t q_exp0[$];
  obs_t q_exp1[$];

  // Reference model: state 0=idle 1=run 2=drain, plus the list of live instructions' stages.
  int m_state [2];
  int m_pc    [2];
  int m_cnt   [2];
  int m_stg   [2][N];
  int m_n     [2];

  function automatic int pcmask(input int d);
    return (d == 0) ? 15 : 255;
  endfunction

  function automatic int cntmask(input int d);
    return (d == 0) ? 65535 : 63;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d] = 0; m_pc[d] = 0; m_cnt[d] = 0; m_n[d] = 0;
    end
  endtask

  function automatic obs_t model_obs(input int d);
    obs_t o;
    o = '0;
    for (int k = 0; k < m_n[d]; k++) o.sv[m_stg[d][k]] = 1'b1;
    o.pc   = 8'(m_pc[d]);
    o.cnt  = 16'(m_cnt[d]);
    o.busy = (m_state[d] != 0);
    o.fe   = o.sv[0] & ~in_stall[d];
    o.rt   = o.sv[N-1] & ~in_stall[d];
    return o;
  endfunction

  task automatic m_step(input int d);
    int nxt[N];
    int nn;
    bit fetched, retired, sq;
    int rpc;
    nn = 0; fetched = 0; retired = 0;
    if (in_stall[d]) return;
    rpc = int'(in_rpc[d]) & pcmask(d);
    sq = (d == 1) && in_redir[d] && (m_state[d] != 0);
    for (int k = 0; k < m_n[d]; k++) begin
      if (m_stg[d][k] == 0) fetched = 1;
      if (m_stg[d][k] == N-1) retired = 1;
      else if (!(sq && (m_stg[d][k] + 1 < R))) begin
        nxt[nn] = m_stg[d][k] + 1;
        nn++;
      end
    end
    if (retired) m_cnt[d] = (m_cnt[d] + 1) & cntmask(d);
    if (m_state[d] == 0) begin
      if (in_start[d]) begin
        m_state[d] = 1; nxt[nn] = 0; nn++;
      end
    end else if (d == 0) begin
      if (retired) begin
        m_pc[d] = in_redir[d] ? rpc : ((m_pc[d] + 1) & pcmask(d));
        if (m_state[d] == 2) m_state[d] = 0;
        else begin
          nxt[nn] = 0; nn++;
          if (in_halt[d]) m_state[d] = 2;
        end
      end else if (m_state[d] == 1 && in_halt[d]) begin
        m_state[d] = 2;
      end
    end else begin
      if (in_redir[d]) m_pc[d] = rpc;
      else if (fetched) m_pc[d] = (m_pc[d] + 1) & pcmask(d);
      if (m_state[d] == 1 && !in_halt[d] && !in_redir[d]) begin
        nxt[nn] = 0; nn++;
      end
      if (m_state[d] == 1 && in_halt[d]) m_state[d] = 2;
      else if (m_state[d] == 2 && nn == 0) m_state[d] = 0;
    end
    for (int k = 0; k < nn; k++) m_stg[d][k] = nxt[k];
    m_n[d] = nn;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic set_idle();
    for (int d = 0; d < 2; d++) begin
      in_start[d] = 0; in_stall[d] = 0; in_halt[d] = 0; in_redir[d] = 0; in_rpc[d] = 8'h00;
    end
  endtask

  // Push this cycle's expectation, advance the model across the coming edge.
  task automatic cycle();
    q_exp0.push_back(model_obs(0));
    q_exp1.push_back(model_obs(1));
    if (reset_n) begin
      m_step(0);
      m_step(1);
    end
    @(negedge clock);
    #1;
  endtask

  function automatic obs_t dut_obs(input int d);
    obs_t o;
    if (d == 0) begin
      o.pc = 8'(mc_if.pc); o.sv = mc_if.stage_valid; o.fe = mc_if.fetch_en;
      o.rt = mc_if.retire; o.busy = mc_if.busy; o.cnt = 16'(mc_if.instr_count);
    end else begin
      o.pc = pl_if.pc; o.sv = pl_if.stage_valid; o.fe = pl_if.fetch_en;
      o.rt = pl_if.retire; o.busy = pl_if.busy; o.cnt = 16'(pl_if.instr_count);
    end
    return o;
  endfunction

  task automatic compare(input int d, input obs_t e);
    obs_t a;
    a = dut_obs(d);
    n_total++;
    if (a == e) n_pass++;
    else $display("FAIL %s at %0t: got pc=%0h sv=%b fe=%b rt=%b busy=%b cnt=%0d, expected pc=%0h sv=%b fe=%b rt=%b busy=%b cnt=%0d",
                  (d == 0) ? "mc_obs" : "pl_obs", $time, a.pc, a.sv, a.fe, a.rt, a.busy, a.cnt,
                  e.pc, e.sv, e.fe, e.rt, e.busy, e.cnt);
  endtask

  // Monitor: pops one expectation per instance per cycle, well after inputs settle.
  initial begin
    forever begin
      @(negedge clock);
      #3;
      if (q_exp0.size() > 0) compare(0, q_exp0.pop_front());
      if (q_exp1.size() > 0) compare(1, q_exp1.pop_front());
    end
  end

  task automatic reset_zero_checks(input string tag);
    chk({tag, "_mc_pc"},   int'(mc_if.pc), 0);
    chk({tag, "_mc_sv"},   int'(mc_if.stage_valid), 0);
    chk({tag, "_mc_busy"}, int'(mc_if.busy), 0);
    chk({tag, "_mc_cnt"},  int'(mc_if.instr_count), 0);
    chk({tag, "_pl_pc"},   int'(pl_if.pc), 0);
    chk({tag, "_pl_sv"},   int'(pl_if.stage_valid), 0);
    chk({tag, "_pl_fe"},   int'(pl_if.fetch_en), 0);
    chk({tag, "_pl_rt"},   int'(pl_if.retire), 0);
  endtask

  initial begin
    int rt_seen;
    set_idle();
    m_reset();
    @(negedge clock);
    #1;
    reset_zero_checks("por");
    reset_n = 1'b1;

    // Start both instances together.
    in_start[0] = 1; in_start[1] = 1;
    cycle();
    set_idle();
    for (int i = 0; i < 20; i++) cycle();
    chk("pl_pc_after20",  int'(pl_if.pc), 20);
    chk("pl_cnt_after20", int'(pl_if.instr_count), 16);
    chk("pl_sv_full",     int'(pl_if.stage_valid), 31);

    // Redirect from stage 2 squashes stages 1..2 worth of younger work.
    in_redir[1] = 1; in_rpc[1] = 8'h40;
    cycle();
    set_idle();
    chk("pl_redir_sv", int'(pl_if.stage_valid), 5'b11100);
    chk("pl_redir_pc", int'(pl_if.pc), 8'h40);
    cycle();
    chk("pl_redir_sv2", int'(pl_if.stage_valid), 5'b11001);
    chk("pl_redir_pc2", int'(pl_if.pc), 8'h40);
    for (int i = 0; i < 58; i++) cycle();
    chk("mc_cnt_16",   int'(mc_if.instr_count), 16);
    chk("mc_pc_wrap",  int'(mc_if.pc), 0);
    chk("mc_sv_token", int'(mc_if.stage_valid), 1);

    // Three stall cycles with halt/redirect pulsed: nothing may move.
    for (int i = 0; i < 3; i++) begin
      for (int d = 0; d < 2; d++) begin
        in_stall[d] = 1; in_halt[d] = 1; in_redir[d] = 1; in_rpc[d] = 8'h33;
      end
      #1;
      chk("stall_mc_fe", int'(mc_if.fetch_en), 0);
      chk("stall_pl_rt", int'(pl_if.retire), 0);
      cycle();
    end
    set_idle();
    chk("stall_mc_pc",  int'(mc_if.pc), 0);
    chk("stall_mc_cnt", int'(mc_if.instr_count), 16);
    chk("stall_mc_sv",  int'(mc_if.stage_valid), 1);

    // Halt: multicycle with token at stage 2, pipelined with a full pipe.
    cycle();
    in_halt[0] = 1; in_halt[1] = 1;
    cycle();
    set_idle();
    rt_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (pl_if.retire) rt_seen++;
      cycle();
    end
    chk("pl_halt_retires", rt_seen, 4);
    chk("pl_halt_busy",    int'(pl_if.busy), 0);
    chk("mc_halt_busy",    int'(mc_if.busy), 0);
    chk("mc_halt_pc",      int'(mc_if.pc), 1);
    chk("mc_halt_cnt",     int'(mc_if.instr_count), 17);

    // Mid-run asynchronous reset with the token in stage 3.
    in_start[0] = 1; in_start[1] = 1;
    cycle();
    set_idle();
    cycle();
    cycle();
    chk("mc_tok_stage3", int'(mc_if.stage_valid), 5'b00100);
    reset_n = 1'b0;
    #1;
    reset_zero_checks("midrst");
    m_reset();
    cycle();
    reset_n = 1'b1;
    in_start[0] = 1; in_start[1] = 1;
    cycle();
    set_idle();
    chk("rst_restart_mc_pc", int'(mc_if.pc), 0);
    chk("rst_restart_mc_sv", int'(mc_if.stage_valid), 1);
    chk("rst_restart_pl_sv", int'(pl_if.stage_valid), 1);

    // Randomised phase against the reference model.
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        in_start[d] = ($urandom_range(0, 9) < 3);
        in_stall[d] = ($urandom_range(0, 99) < 15);
        in_halt[d]  = ($urandom_range(0, 99) < 3);
        in_redir[d] = ($urandom_range(0, 99) < 10);
        in_rpc[d]   = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 599) == 0) begin
        reset_n = 1'b0;
        #1;
        m_reset();
        cycle();
        reset_n = 1'b1;
      end else begin
        cycle();
      end
    end
    set_idle();
    @(negedge clock);
    #5;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
